// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    localparam int TXN_ADDR_W = 32;
    localparam int TXN_DATA_W = 32;

    localparam logic PORT_LSU = 1'b0;
    localparam logic PORT_IF  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [TXN_ADDR_W-1:0] addr;
        logic                  we;
        logic [TXN_DATA_W-1:0] wdata;
    } txn_t;

endpackage

// File: rtl/mem_arb_sel.sv
// rtl/mem_arb_sel.sv - fixed-priority winner select with a port-1 starvation guard
module mem_arb_sel #(
    parameter int STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_grant_en,
    output logic o_gnt0,
    output logic o_gnt1
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] r_starve;
    logic          w_force1;
    logic          w_win1;
    logic          w_grant;

    assign w_force1 = (r_starve == SW'(STARVE_MAX));
    assign w_win1   = i_req1 & (~i_req0 | w_force1);
    assign w_grant  = i_grant_en & (i_req0 | i_req1);
    assign o_gnt0   = w_grant & ~w_win1;
    assign o_gnt1   = w_grant & w_win1;

    // Counts port-0 wins while port 1 is kept waiting; saturates at the limit
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_starve <= '0;
        end else if (!i_req1 || o_gnt1) begin
            r_starve <= '0;
        end else if (o_gnt0 && !w_force1) begin
            r_starve <= r_starve + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between LSU (port 0) and fetch (port 1)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = TXN_ADDR_W,
    parameter int DATA_W     = TXN_DATA_W,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_err0,
    output logic              o_err1,
    output logic              o_proc_req,
    output logic [ADDR_W-1:0] o_addr_out,
    output logic              o_we_out,
    output logic [DATA_W-1:0] o_wdata_out,
    input  logic              i_mem_rdy,
    input  logic              i_mem_valid,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int TW = $clog2(TIMEOUT);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic              r_owner;
    txn_t              r_txn;
    logic              r_proc_req;
    logic [TW-1:0]     r_tmo;
    logic [1:0]        r_rvalid;
    logic [1:0]        r_err;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_sel_gnt0;
    logic              w_sel_gnt1;
    logic              w_idle;
    logic              w_resp;
    logic              w_tmo;
    logic [DATA_W-1:0] w_resp_data;
    txn_t              w_txn0;
    txn_t              w_txn1;

    assign w_idle = (r_state == ST_IDLE);
    assign w_txn0 = '{addr: i_addr0, we: i_we0, wdata: i_wdata0};
    assign w_txn1 = '{addr: i_addr1, we: i_we1, wdata: i_wdata1};

    mem_arb_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req0     (i_req0),
        .i_req1     (i_req1),
        .i_grant_en (w_idle),
        .o_gnt0     (w_sel_gnt0),
        .o_gnt1     (w_sel_gnt1)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_sel_gnt0 || w_sel_gnt1) w_next = ST_REQ;
            ST_REQ:  if (i_mem_rdy) w_next = i_mem_valid ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (i_mem_valid || w_tmo) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // A zero-latency memory answers in the same REQ cycle it accepts the request
    always_comb begin
        o_gnt0      = w_sel_gnt0;
        o_gnt1      = w_sel_gnt1;
        w_resp      = ((r_state == ST_REQ) && i_mem_rdy && i_mem_valid)
                    || ((r_state == ST_WAIT) && i_mem_valid);
        w_tmo       = (r_state == ST_WAIT) && !i_mem_valid && (r_tmo == TW'(TIMEOUT - 1));
        w_resp_data = r_txn.we ? '0 : i_mem_rdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_owner    <= PORT_LSU;
            r_txn      <= '0;
            r_proc_req <= 1'b0;
            r_tmo      <= '0;
            r_rvalid   <= '0;
            r_err      <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            if (w_idle && (w_sel_gnt0 || w_sel_gnt1)) begin
                r_owner    <= w_sel_gnt1 ? PORT_IF : PORT_LSU;
                r_txn      <= w_sel_gnt1 ? w_txn1 : w_txn0;
                r_proc_req <= 1'b1;
            end
            if ((r_state == ST_REQ) && i_mem_rdy) begin
                r_proc_req <= 1'b0;
            end
            if (r_state == ST_WAIT) begin
                r_tmo <= (w_resp || w_tmo) ? '0 : r_tmo + 1'b1;
            end
            if (w_resp) begin
                r_rvalid[r_owner] <= 1'b1;
                if (r_owner == PORT_IF) begin
                    r_rdata1 <= w_resp_data;
                end else begin
                    r_rdata0 <= w_resp_data;
                end
            end
            if (w_tmo) begin
                r_err[r_owner] <= 1'b1;
            end
        end
    end

    assign o_rvalid0   = r_rvalid[0];
    assign o_rvalid1   = r_rvalid[1];
    assign o_err0      = r_err[0];
    assign o_err1      = r_err[1];
    assign o_rdata0    = r_rdata0;
    assign o_rdata1    = r_rdata1;
    assign o_proc_req  = r_proc_req;
    assign o_addr_out  = r_txn.addr;
    assign o_we_out    = r_txn.we;
    assign o_wdata_out = r_txn.wdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port (proc_req / mem_rdy / valid handshake) between two requesters: port 0 is the load/store unit, port 1 is instruction fetch.
- Keeps at most one transaction outstanding at a time.
- Routes each response back to the requester that owns it.
- Applies an anti-starvation guard and a response timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive port-0 grants allowed while port 1 waits; after that, port 1 is forced.
- TIMEOUT, 64, number of WAIT cycles without mem_valid before an error is raised.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- req0/req1  in  1  request; held high until gnt.
- addr0/addr1  in  ADDR_W  request address.
- we0/we1  in  1  1 = store, 0 = load.
- wdata0/wdata1  in  DATA_W  store data.
- gnt0/gnt1  out  1  request accepted (combinational, one cycle).
- rvalid0/rvalid1  out  1  response pulse (registered).
- rdata0/rdata1  out  DATA_W  load data; 0 for stores.
- err0/err1  out  1  timeout pulse, same timing as rvalid.
- proc_req  out  1  memory request.
- addr_out  out  ADDR_W  memory address.
- we_out  out  1  memory write enable.
- wdata_out  out  DATA_W  memory write data.
- mem_rdy  in  1  memory accepts request.
- mem_valid  in  1  memory response (read data or write ack).
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE, starve counter and timeout counter = 0, owner = 0.
  - Outputs proc_req, addr_out, we_out, wdata_out, all rvalid/rdata/err = 0.
  - Reset mid-transaction abandons it. mem_valid arriving after reset is ignored in IDLE.
- Three states: IDLE, REQ, WAIT.
- IDLE:
  - No req: stay in IDLE.
  - Any req: select a winner and drive its gnt high in the same cycle.
  - At the edge, latch the winner's addr/we/wdata into the output registers, latch owner, set proc_req=1, go to REQ.
- Selection:
  - Only one requesting: that one wins.
  - Both requesting: port 0 wins, unless starve counter == STARVE_MAX, in which case port 1 wins.
  - Starve counter increments when port 0 wins while req1=1, saturating at STARVE_MAX. It clears whenever port 1 wins or req1=0.
- REQ:
  - Hold proc_req and the output registers stable until mem_rdy=1.
  - mem_rdy=1 and mem_valid=0: proc_req<=0, go to WAIT.
  - mem_rdy=1 and mem_valid=1 in the same cycle (zero-latency memory): treat as a response (see below), proc_req<=0, go to IDLE.
  - mem_valid without mem_rdy is ignored.
- WAIT:
  - Timeout counter increments each cycle.
  - mem_valid=1: next cycle rvalid[owner]=1 and rdata[owner]=mem_rdata (0 if the transaction was a store); counter cleared; go to IDLE.
  - Counter reaches TIMEOUT-1 with no mem_valid: next cycle err[owner]=1 and rvalid[owner]=0; go to IDLE.
  - mem_valid on the timeout cycle itself takes precedence over the timeout.
- Response outputs are single-cycle pulses.
  - The non-owner port always sees rvalid/err/rdata = 0.
  - rdata returns to 0 after the pulse.
- Back-to-back: IDLE may grant in the same cycle that rvalid is pulsing. Minimum cycle time per transaction is 3 clocks (IDLE, REQ, response).
- gnt0 and gnt1 are never both high; gnt is never high outside IDLE.
- Counter widths are clog2(TIMEOUT) and clog2(STARVE_MAX+1); no wrap-around is permitted.

Decomposition:
- Package mem_arb_pkg contains:
  - state enum (IDLE, REQ, WAIT);
  - requester-id constants PORT_LSU=0, PORT_IF=1;
  - transaction struct {addr, we, wdata}.
- Sub-module mem_arb_sel: combinational winner selection plus the registered starvation counter.
- FSM and datapath stay in the top module.

Test Plan:
- Single load: req0, addr0=0x100, we0=0; mem_rdy one cycle after proc_req; mem_valid 2 cycles later with 0xDEADBEEF → gnt0 in cycle 0, proc_req/addr_out=0x100 in cycle 1, rvalid0=1 and rdata0=0xDEADBEEF one cycle after mem_valid, rvalid1=0 throughout.
- Contention: req0 and req1 held high continuously; memory always ready with 1-cycle latency → grant order 0,0,0,0,1,0,0,0,0,1; never both gnt high.
- Zero-latency memory: mem_rdy=mem_valid=1 in the first REQ cycle; store we0=1, wdata0=0x55 → wdata_out=0x55, we_out=1, rvalid0 next cycle, rdata0=0, FSM returns to IDLE.
- Timeout: TIMEOUT=8, mem_rdy given, mem_valid never asserted → err1=1 exactly 8 WAIT cycles after entry, no rvalid1; next request is granted normally.
- Reset mid-op: rst=0 during WAIT, then mem_valid=1 the cycle after rst=1 → all outputs 0, no rvalid, state IDLE, next request serviced correctly.
- Backpressure: mem_rdy held low for 10 cycles → proc_req, addr_out, we_out, wdata_out stable for all 10 cycles; no gnt issued.
